// File: rtl/frame_buffer_dbl_if.sv
// Camera-write and display-read signals of frame_buffer_dbl. master = capture/display side, slave = buffer.
interface frame_buffer_dbl_if #(
  parameter int c_nb_img_pxls = 13,
  parameter int c_nb_buf      = 12
);
  logic                     wr_frame_start;
  logic                     wr_pxl_en;
  logic [c_nb_buf-1:0]      wr_pxl;
  logic                     wr_busy;
  logic                     wr_frame_done;
  logic                     rd_frame_start;
  logic [c_nb_img_pxls-1:0] rd_addr;
  logic [c_nb_buf-1:0]      rd_pxl;
  logic                     frame_pending;
  logic                     rd_bank;

  modport master (
    output wr_frame_start, wr_pxl_en, wr_pxl, rd_frame_start, rd_addr,
    input  wr_busy, wr_frame_done, rd_pxl, frame_pending, rd_bank
  );

  modport slave (
    input  wr_frame_start, wr_pxl_en, wr_pxl, rd_frame_start, rd_addr,
    output wr_busy, wr_frame_done, rd_pxl, frame_pending, rd_bank
  );
endinterface

// File: rtl/frame_buffer_dbl.sv
// Ping-pong frame buffer: camera fills the back bank, display reads the front bank; FRAME_BUFFER_DROP_CNT_EN adds drop_cnt.
// rd_pxl one cycle after rd_addr; no backpressure: writer is never stalled, whole frames are dropped instead.
module frame_buffer_dbl #(
  parameter int c_img_cols    = 80,
  parameter int c_img_rows    = 60,
  parameter int c_img_pxls    = c_img_cols*c_img_rows,
  parameter int c_nb_img_pxls = 13,
  parameter int c_nb_buf      = 12
) (
  input  logic               clk,
  input  logic               rst,
  frame_buffer_dbl_if.slave  bus
`ifdef FRAME_BUFFER_DROP_CNT_EN
  ,
  output logic [7:0]         drop_cnt
`endif
);

  localparam int c_nb_ram = c_nb_img_pxls + 1;
  localparam logic [c_nb_img_pxls-1:0] c_last     = c_nb_img_pxls'(c_img_pxls - 1);
  localparam logic [c_nb_ram-1:0]      c_bank_ofs = c_nb_ram'(c_img_pxls);

  typedef enum logic {s_idle, s_write} state_t;

  state_t                   state, state_nxt;
  logic [c_nb_img_pxls-1:0] wr_addr, wr_addr_nxt, wr_waddr;
  logic                     wr_en, wr_last, drop_evt, swap;
  logic                     rd_bank, frame_pending, wr_frame_done;
  logic [c_nb_buf-1:0]      rd_pxl;
  logic [c_nb_buf-1:0]      mem [2*c_img_pxls];

  function automatic logic [c_nb_ram-1:0] phys(input logic bank, input logic [c_nb_img_pxls-1:0] addr);
    return bank ? c_bank_ofs + c_nb_ram'(addr) : c_nb_ram'(addr);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= s_idle;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      s_idle:  if (bus.wr_frame_start && !frame_pending) state_nxt = s_write;
      s_write: if (!bus.wr_frame_start && bus.wr_pxl_en && wr_addr == c_last) state_nxt = s_idle;
      default: state_nxt = s_idle;
    endcase
  end

  // A resync in WRITE takes priority over a normal pixel and may carry pixel 0 itself.
  always_comb begin
    wr_en       = 1'b0;
    wr_waddr    = wr_addr;
    wr_addr_nxt = wr_addr;
    wr_last     = 1'b0;
    drop_evt    = 1'b0;
    case (state)
      s_idle: begin
        if (bus.wr_frame_start) begin
          if (frame_pending) drop_evt    = 1'b1;
          else               wr_addr_nxt = '0;
        end
      end
      s_write: begin
        if (bus.wr_frame_start) begin
          drop_evt    = 1'b1;
          wr_waddr    = '0;
          wr_en       = bus.wr_pxl_en;
          wr_addr_nxt = bus.wr_pxl_en ? c_nb_img_pxls'(1) : '0;
        end else if (bus.wr_pxl_en) begin
          wr_en = 1'b1;
          if (wr_addr == c_last) begin
            wr_last     = 1'b1;
            wr_addr_nxt = '0;
          end else begin
            wr_addr_nxt = wr_addr + c_nb_img_pxls'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // frame_pending is never set while a swap could see it, so the last pixel and a swap request never collide.
  assign swap = bus.rd_frame_start && frame_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr       <= '0;
      frame_pending <= 1'b0;
      rd_bank       <= 1'b0;
      wr_frame_done <= 1'b0;
    end else begin
      wr_addr       <= wr_addr_nxt;
      wr_frame_done <= wr_last;
      if (wr_last) begin
        frame_pending <= 1'b1;
      end else if (swap) begin
        frame_pending <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[phys(~rd_bank, wr_waddr)] <= bus.wr_pxl;
  end

  always_ff @(posedge clk) begin
    if (rst)                       rd_pxl <= '0;
    else if (bus.rd_addr <= c_last) rd_pxl <= mem[phys(rd_bank, bus.rd_addr)];
    else                           rd_pxl <= '0;
  end

`ifdef FRAME_BUFFER_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                            drop_cnt <= '0;
    else if (drop_evt && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`else
  logic unused_drop_evt;
  assign unused_drop_evt = drop_evt;
`endif

  assign bus.wr_busy       = (state == s_write);
  assign bus.wr_frame_done = wr_frame_done;
  assign bus.frame_pending = frame_pending;
  assign bus.rd_bank       = rd_bank;
  assign bus.rd_pxl        = rd_pxl;

endmodule

// File: tb/tb_frame_buffer_dbl.sv
// Directed bench for frame_buffer_dbl on a 4x3 image; FRAME_BUFFER_DROP_CNT_EN also checks drop_cnt.
module tb_frame_buffer_dbl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  frame_buffer_dbl_if #(.c_nb_img_pxls(4), .c_nb_buf(12)) fbi ();

`ifdef FRAME_BUFFER_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  frame_buffer_dbl #(
    .c_img_cols(4), .c_img_rows(3), .c_img_pxls(12), .c_nb_img_pxls(4), .c_nb_buf(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(fbi)
`ifdef FRAME_BUFFER_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_px(input logic [11:0] d);
    fbi.wr_pxl_en = 1'b1;
    fbi.wr_pxl    = d;
    step();
    fbi.wr_pxl_en = 1'b0;
  endtask

  task automatic start_frame();
    fbi.wr_frame_start = 1'b1;
    step();
    fbi.wr_frame_start = 1'b0;
  endtask

  task automatic swap_req();
    fbi.rd_frame_start = 1'b1;
    step();
    fbi.rd_frame_start = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [11:0] exp, input string tag);
    fbi.rd_addr = a;
    step();
    chk(tag, fbi.rd_pxl, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    fbi.wr_frame_start = 1'b0;
    fbi.wr_pxl_en      = 1'b0;
    fbi.wr_pxl         = '0;
    fbi.rd_frame_start = 1'b0;
    fbi.rd_addr        = '0;
    step();
    step();
    chk("rst_busy", fbi.wr_busy, 0);
    chk("rst_pending", fbi.frame_pending, 0);
    chk("rst_bank", fbi.rd_bank, 0);
    chk("rst_done", fbi.wr_frame_done, 0);
    chk("rst_rdpxl", fbi.rd_pxl, 0);
`ifdef FRAME_BUFFER_DROP_CNT_EN
    chk("rst_drop", drop_cnt, 0);
`endif
    rst = 1'b0;
    step();

    // Frame 1: data = addr, into bank 1
    start_frame();
    chk("t1_busy", fbi.wr_busy, 1);
    for (int i = 0; i < 12; i++) begin
      wr_px(12'(i));
      if (i == 10) chk("t1_done_early", fbi.wr_frame_done, 0);
    end
    chk("t1_done", fbi.wr_frame_done, 1);
    chk("t1_pending", fbi.frame_pending, 1);
    chk("t1_busy_end", fbi.wr_busy, 0);
    chk("t1_bank", fbi.rd_bank, 0);
    step();
    chk("t1_done_pulse", fbi.wr_frame_done, 0);

    // Swap to bank 1
    swap_req();
    chk("t2_bank", fbi.rd_bank, 1);
    chk("t2_pending", fbi.frame_pending, 0);
    rd(4'd5, 12'd5, "t2_rd5");
    rd(4'd11, 12'd11, "t2_rd11");

    // Frame 0x100+i into bank 0, then a dropped start while pending
    start_frame();
    for (int i = 0; i < 12; i++) wr_px(12'h100 + 12'(i));
    chk("t3_pending", fbi.frame_pending, 1);
    start_frame();
    chk("t3_busy", fbi.wr_busy, 0);
    chk("t3_pending_kept", fbi.frame_pending, 1);
`ifdef FRAME_BUFFER_DROP_CNT_EN
    chk("t3_drop", drop_cnt, 1);
`endif
    wr_px(12'hFFF);
    rd(4'd5, 12'd5, "t3_rd_front");
    swap_req();
    chk("t3_bank", fbi.rd_bank, 0);
    rd(4'd5, 12'h105, "t3_rd5");

    // Partial frame aborted by resync, then full frame 0xA00+i into bank 1
    start_frame();
    for (int i = 0; i < 7; i++) wr_px(12'hB00 + 12'(i));
    start_frame();
    chk("t4_busy_resync", fbi.wr_busy, 1);
`ifdef FRAME_BUFFER_DROP_CNT_EN
    chk("t4_drop", drop_cnt, 2);
`endif
    for (int i = 0; i < 12; i++) wr_px(12'hA00 + 12'(i));
    chk("t4_pending", fbi.frame_pending, 1);
    swap_req();
    chk("t4_bank", fbi.rd_bank, 1);
    rd(4'd3, 12'hA03, "t4_rd3");
    rd(4'd6, 12'hA06, "t4_rd6");

    // Resync carrying pixel 0; last pixel coincides with rd_frame_start
    start_frame();
    for (int i = 0; i < 3; i++) wr_px(12'hD00 + 12'(i));
    fbi.wr_frame_start = 1'b1;
    wr_px(12'hC00);
    fbi.wr_frame_start = 1'b0;
`ifdef FRAME_BUFFER_DROP_CNT_EN
    chk("t5_drop", drop_cnt, 3);
`endif
    for (int i = 1; i < 12; i++) begin
      if (i == 11) fbi.rd_frame_start = 1'b1;
      wr_px(12'hC00 + 12'(i));
      fbi.rd_frame_start = 1'b0;
    end
    chk("t5_done", fbi.wr_frame_done, 1);
    chk("t5_noswap_bank", fbi.rd_bank, 1);
    chk("t5_noswap_pending", fbi.frame_pending, 1);
    step();
    chk("t5_bank_hold", fbi.rd_bank, 1);
    swap_req();
    chk("t5_bank", fbi.rd_bank, 0);
    chk("t5_pending", fbi.frame_pending, 0);
    rd(4'd0, 12'hC00, "t5_rd0");
    rd(4'd2, 12'hC02, "t5_rd2");
    rd(4'd11, 12'hC0B, "t5_rd11");

    // Out-of-range read addresses
    for (int a = 12; a < 16; a++) rd(4'(a), 12'h000, "t6_rd_oor");

    // Frame 0xE00+i into bank 1, swap, then reset mid-write
    start_frame();
    for (int i = 0; i < 12; i++) wr_px(12'hE00 + 12'(i));
    swap_req();
    chk("t6_bank", fbi.rd_bank, 1);
    rd(4'd0, 12'hE00, "t6_rd0");
    start_frame();
    for (int i = 0; i < 4; i++) wr_px(12'h300 + 12'(i));
    chk("t6_busy", fbi.wr_busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_pending", fbi.frame_pending, 0);
    chk("t6_rst_bank", fbi.rd_bank, 0);
    chk("t6_rst_busy", fbi.wr_busy, 0);
    chk("t6_rst_rdpxl", fbi.rd_pxl, 0);
`ifdef FRAME_BUFFER_DROP_CNT_EN
    chk("t6_rst_drop", drop_cnt, 0);
`endif
    start_frame();
    chk("t6_restart_busy", fbi.wr_busy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
